// File: rtl/rr_bus_arbiter_if.sv
// ============================================================================
// Module : rr_bus_arbiter_if
// Brief  : Request, grant and data bundle between requesters and the arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface rr_bus_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_BUS = 2,
  parameter int SEL_W     = $clog2(N_REQ)
);

  logic [N_REQ-1:0]                req;
  logic [N_REQ-1:0][WIDTH_BUS-1:0] data_in;
  logic [N_REQ-1:0]                gnt;
  logic [SEL_W-1:0]                sel;
  logic                            busy;
  logic [WIDTH_BUS-1:0]            data_out;

  modport master (
    output req,
    output data_in,
    input  gnt,
    input  sel,
    input  busy,
    input  data_out
  );

  modport slave (
    input  req,
    input  data_in,
    output gnt,
    output sel,
    output busy,
    output data_out
  );

endinterface

`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
// ============================================================================
// Module : rr_bus_arbiter
// Brief  : Round-robin bus arbiter with tenure cap, binary select and data mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_bus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_BUS = 2,
  parameter int MAX_HOLD  = 8,
  parameter int SEL_W     = $clog2(N_REQ)
) (
  input  wire              clk,
  input  wire              rst,
  rr_bus_arbiter_if.slave  bus
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_REQ - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             busy_q,  busy_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [N_REQ-1:0] w_others;
  logic             w_owner_req;
  logic             w_grant;
  logic [SEL_W-1:0] w_grant_idx;

  // First set bit of mask in the order ptr, ptr+1, ... wrapping at N_REQ.
  function automatic logic [SEL_W-1:0] f_pick(
    input logic [N_REQ-1:0] mask,
    input logic [SEL_W-1:0] ptr
  );
    logic [SEL_W-1:0] pick;
    int               j;
    pick = ptr;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (mask[j[SEL_W-1:0]]) begin
        pick = j[SEL_W-1:0];
      end
    end
    return pick;
  endfunction

  assign w_others    = bus.req & ~gnt_q;
  assign w_owner_req = |(bus.req & gnt_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    w_grant     = 1'b0;
    w_grant_idx = '0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          w_grant     = 1'b1;
          w_grant_idx = f_pick(bus.req, ptr_q);
        end
      end
      ST_OWN: begin
        if (!w_owner_req) begin
          if (|w_others) begin
            w_grant     = 1'b1;
            w_grant_idx = f_pick(w_others, ptr_q);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
          end
        end else if ((hold_q == HOLD_LAST) && (|w_others)) begin
          // ptr already points past the owner, so it is searched last and never wins.
          w_grant     = 1'b1;
          w_grant_idx = f_pick(w_others, ptr_q);
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase

    if (w_grant) begin
      state_d = ST_OWN;
      gnt_d   = N_REQ'(1) << w_grant_idx;
      sel_d   = w_grant_idx;
      busy_d  = 1'b1;
      ptr_d   = (w_grant_idx == SEL_LAST) ? '0 : w_grant_idx + 1'b1;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.data_out = busy_q ? bus.data_in[sel_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
// ============================================================================
// Module : tb_rr_bus_arbiter
// Brief  : Directed vectors with a queued scoreboard for rr_bus_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rr_bus_arbiter;

  localparam int N_REQ     = 4;
  localparam int WIDTH_BUS = 2;
  localparam int MAX_HOLD  = 8;
  localparam int SEL_W     = 2;
  localparam int STARVE    = (N_REQ - 1) * MAX_HOLD;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  g;
    logic [1:0]  s;
    logic        b;
    logic [1:0]  d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_bus_arbiter_if #(.N_REQ(N_REQ), .WIDTH_BUS(WIDTH_BUS), .SEL_W(SEL_W)) bus_if ();

  rr_bus_arbiter #(
    .N_REQ    (N_REQ),
    .WIDTH_BUS(WIDTH_BUS),
    .MAX_HOLD (MAX_HOLD),
    .SEL_W    (SEL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   n_push   = 0;
  logic checking = 1'b0;
  int   wait_cnt [N_REQ];

  task automatic step(input logic [3:0] r, input logic rs, input logic [3:0] eg,
                      input logic [1:0] es, input logic eb, input logic [1:0] ed);
    exp_t e;
    @(negedge clk);
    bus_if.req = r;
    rst        = rs;
    @(posedge clk);
    e.id = 16'(n_push);
    e.g  = eg;
    e.s  = es;
    e.b  = eb;
    e.d  = ed;
    exp_q.push_back(e);
    n_push++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      checking = 1'b1;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy, bus_if.data_out} !==
          {mon_e.g, mon_e.s, mon_e.b, mon_e.d}) begin
        n_bad++;
        $display("FAIL vec%0d: got gnt=%b sel=%0d busy=%b data_out=%0d, expected gnt=%b sel=%0d busy=%b data_out=%0d",
                 mon_e.id, bus_if.gnt, bus_if.sel, bus_if.busy, bus_if.data_out,
                 mon_e.g, mon_e.s, mon_e.b, mon_e.d);
      end
    end
    if (checking) begin
      if ($countones(bus_if.gnt) > 1) begin
        n_bad++;
        $display("FAIL onehot: gnt=%b, required one-hot or zero", bus_if.gnt);
      end
      if (bus_if.gnt[bus_if.sel] !== bus_if.busy) begin
        n_bad++;
        $display("FAIL gnt_sel: gnt[sel]=%b busy=%b, required equal",
                 bus_if.gnt[bus_if.sel], bus_if.busy);
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst || !checking) begin
        wait_cnt[i] = 0;
      end else if (bus_if.req[i] && !bus_if.gnt[i]) begin
        wait_cnt[i] = wait_cnt[i] + 1;
        if (wait_cnt[i] > STARVE) begin
          n_bad++;
          $display("FAIL starve: req%0d waited %0d cycles, limit %0d", i, wait_cnt[i], STARVE);
          wait_cnt[i] = 0;
        end
      end else begin
        wait_cnt[i] = 0;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus_if.req     = '0;
    bus_if.data_in = {2'd2, 2'd1, 2'd3, 2'd2};

    // reset held with all requests asserted
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);
    step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);

    // single requester from idle, then release
    step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd1);
    step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 2'd0);

    // full contention, each owner leaves after one cycle
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);
    step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd2);
    step(4'b1110, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd3);
    step(4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd1);
    step(4'b1011, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd2);
    step(4'b0111, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd2);
    step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0);

    // tenure cap: owner 0 never drops
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd2);
    end
    step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd3);
    step(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd0);

    // lone requester saturates its counter, then yields at once
    for (int i = 0; i < 20; i++) begin
      step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd2);
    end
    step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd2);

    // reset mid-tenure clears ptr
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd2);
    step(4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);
    step(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd3);
    step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd2);
    step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 2'd0);

    @(negedge clk);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
